// File: rtl/boreal_telemetry_tx_if.sv
// Debug status register read port between the telemetry streamer (master)
// and the status register file (slave).
interface boreal_telemetry_tx_if;
  logic [2:0]  dbg_addr;
  logic        dbg_rd_en;
  logic [15:0] dbg_rd_data;

  modport master (output dbg_addr, output dbg_rd_en, input dbg_rd_data);
  modport slave  (input dbg_addr, input dbg_rd_en, output dbg_rd_data);
endinterface

// File: rtl/boreal_telemetry_tx.sv
// Periodic telemetry streamer: sweeps the eight debug status registers and sends them as an
// 18-byte 8N1 UART frame (sync byte, 16 data bytes, XOR checksum).
module boreal_telemetry_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FRAME_PERIOD = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  boreal_telemetry_tx_if.master dbg,
  output logic                  o_uart_tx,
  output logic                  o_frame_busy,
  output logic [15:0]           o_frame_count,
  output logic                  o_overrun
);

  localparam logic [23:0] PeriodLast = 24'(FRAME_PERIOD - 1);
  localparam logic [15:0] BitLast    = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  SyncByte   = 8'hA5;

  typedef enum logic [2:0] {
    StIdle, StSync, StRdReq, StRdWait, StTxHi, StTxLo, StTxCk, StDone
  } state_e;

  typedef enum logic [1:0] {SerIdle, SerStart, SerData, SerStop} ser_e;

  // Period counter
  logic [23:0] r_pcnt;
  logic        w_trig;

  assign w_trig = i_enable && (r_pcnt == PeriodLast);

  always_ff @(posedge clk) begin
    if (rst || !i_enable || w_trig) r_pcnt <= '0;
    else                            r_pcnt <= r_pcnt + 24'd1;
  end

  // Byte serializer
  ser_e        r_ser_state, w_ser_state_d;
  logic [15:0] r_ser_clk, w_ser_clk_d;
  logic [2:0]  r_ser_bit, w_ser_bit_d;
  logic [7:0]  r_ser_shift, w_ser_shift_d;
  logic        r_tx, w_tx_d;
  logic        w_ser_load;
  logic [7:0]  w_ser_byte;
  logic        w_bit_end, w_ser_busy, w_ser_done;

  assign w_bit_end  = (r_ser_clk == BitLast);
  assign w_ser_busy = (r_ser_state != SerIdle);
  assign w_ser_done = (r_ser_state == SerStop) && w_bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ser_state <= SerIdle;
      r_ser_clk   <= '0;
      r_ser_bit   <= '0;
      r_ser_shift <= '0;
      r_tx        <= 1'b1;
    end else begin
      r_ser_state <= w_ser_state_d;
      r_ser_clk   <= w_ser_clk_d;
      r_ser_bit   <= w_ser_bit_d;
      r_ser_shift <= w_ser_shift_d;
      r_tx        <= w_tx_d;
    end
  end

  always_comb begin
    w_ser_state_d = r_ser_state;
    w_ser_clk_d   = r_ser_clk;
    w_ser_bit_d   = r_ser_bit;
    w_ser_shift_d = r_ser_shift;
    w_tx_d        = r_tx;
    unique case (r_ser_state)
      SerIdle: begin
        w_tx_d = 1'b1;
        if (w_ser_load) begin
          w_ser_state_d = SerStart;
          w_ser_clk_d   = '0;
          w_ser_bit_d   = '0;
          w_ser_shift_d = w_ser_byte;
          w_tx_d        = 1'b0;
        end
      end
      SerStart: begin
        w_ser_clk_d = r_ser_clk + 16'd1;
        if (w_bit_end) begin
          w_ser_clk_d   = '0;
          w_ser_state_d = SerData;
          w_tx_d        = r_ser_shift[0];
        end
      end
      SerData: begin
        w_ser_clk_d = r_ser_clk + 16'd1;
        if (w_bit_end) begin
          w_ser_clk_d = '0;
          if (r_ser_bit == 3'd7) begin
            w_ser_state_d = SerStop;
            w_tx_d        = 1'b1;
          end else begin
            w_ser_bit_d   = r_ser_bit + 3'd1;
            w_ser_shift_d = {1'b0, r_ser_shift[7:1]};
            w_tx_d        = r_ser_shift[1];
          end
        end
      end
      SerStop: begin
        w_ser_clk_d = r_ser_clk + 16'd1;
        if (w_bit_end) begin
          w_ser_clk_d   = '0;
          w_ser_state_d = SerIdle;
        end
      end
      default: w_ser_state_d = SerIdle;
    endcase
  end

  // Frame FSM
  state_e      r_state, w_state_d;
  logic [2:0]  r_idx, r_addr;
  logic [15:0] r_hold;
  logic [7:0]  r_ck;
  logic [15:0] r_count;
  logic        r_overrun;
  logic        w_rd_en;

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Byte states load on their first (serializer idle) cycle, then wait for the done pulse.
  always_comb begin
    w_state_d  = r_state;
    w_ser_load = 1'b0;
    w_ser_byte = '0;
    w_rd_en    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_trig) begin
          w_state_d  = StSync;
          w_ser_load = 1'b1;
          w_ser_byte = SyncByte;
        end
      end
      StSync: if (w_ser_done) w_state_d = StRdReq;
      StRdReq: begin
        w_rd_en   = 1'b1;
        w_state_d = StRdWait;
      end
      StRdWait: w_state_d = StTxHi;
      StTxHi: begin
        w_ser_load = !w_ser_busy;
        w_ser_byte = r_hold[15:8];
        if (w_ser_done) w_state_d = StTxLo;
      end
      StTxLo: begin
        w_ser_load = !w_ser_busy;
        w_ser_byte = r_hold[7:0];
        if (w_ser_done) w_state_d = (r_idx == 3'd7) ? StTxCk : StRdReq;
      end
      StTxCk: begin
        w_ser_load = !w_ser_busy;
        w_ser_byte = r_ck;
        if (w_ser_done) w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_addr    <= '0;
      r_hold    <= '0;
      r_ck      <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (r_state == StIdle && w_trig) begin
        r_idx <= '0;
        r_ck  <= '0;
      end
      if (r_state == StRdReq)  r_addr <= r_idx;
      if (r_state == StRdWait) r_hold <= dbg.dbg_rd_data;
      if (w_ser_load && (r_state == StTxHi || r_state == StTxLo)) r_ck <= r_ck ^ w_ser_byte;
      if (r_state == StTxLo && w_ser_done && r_idx != 3'd7) r_idx <= r_idx + 3'd1;
      if (r_state == StDone) r_count <= r_count + 16'd1;
      // A trigger landing in DONE is also an overrun; the frame is dropped.
      if (w_trig && r_state != StIdle) r_overrun <= 1'b1;
    end
  end

  assign dbg.dbg_rd_en  = w_rd_en;
  assign dbg.dbg_addr   = w_rd_en ? r_idx : r_addr;
  assign o_uart_tx      = r_tx;
  assign o_frame_busy   = (r_state != StIdle);
  assign o_frame_count  = r_count;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_boreal_telemetry_tx.sv
// Bench for boreal_telemetry_tx: UART decoder with read-driven scoreboard on instance A
// (period 1000), overrun behaviour on instance B (period 500).
module tb_boreal_telemetry_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, en_a, en_b;
  logic        tx_a, busy_a, ovr_a, tx_b, busy_b, ovr_b;
  logic [15:0] cnt_a, cnt_b;

  boreal_telemetry_tx_if dbg_a ();
  boreal_telemetry_tx_if dbg_b ();

  boreal_telemetry_tx #(.CLKS_PER_BIT(4), .FRAME_PERIOD(1000)) dut_a (
    .clk(clk), .rst(rst_a), .i_enable(en_a), .dbg(dbg_a),
    .o_uart_tx(tx_a), .o_frame_busy(busy_a), .o_frame_count(cnt_a), .o_overrun(ovr_a)
  );

  boreal_telemetry_tx #(.CLKS_PER_BIT(4), .FRAME_PERIOD(500)) dut_b (
    .clk(clk), .rst(rst_b), .i_enable(en_b), .dbg(dbg_b),
    .o_uart_tx(tx_b), .o_frame_busy(busy_b), .o_frame_count(cnt_b), .o_overrun(ovr_b)
  );

  int         total = 0;
  int         bad = 0;
  int         mode = 0;
  logic       in_reset = 1'b1;
  logic [7:0] exp_q[$];
  int         dec_pos = 0;
  int         rx_frames = 0;
  logic [7:0] dec_ck = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] reg_val(input logic [2:0] a);
    logic [15:0] hi;
    if (mode == 0) return (a == 3'd0) ? 16'h1234 : 16'h0000;
    hi = 16'(a) + 16'd1;
    return (hi << 8) | {8'h00, 8'hF0 ^ {5'd0, a}};
  endfunction

  // Status file model; each read pushes the two bytes that must follow on the line.
  always @(posedge clk) begin
    if (dbg_a.dbg_rd_en === 1'b1) begin
      dbg_a.dbg_rd_data <= reg_val(dbg_a.dbg_addr);
      exp_q.push_back(reg_val(dbg_a.dbg_addr) >> 8);
      exp_q.push_back(reg_val(dbg_a.dbg_addr) & 16'h00FF);
    end
  end

  initial dbg_b.dbg_rd_data = 16'h0000;

  // UART decoder for instance A, one sample per clock at the falling edge.
  logic [39:0] smp;
  logic        aborted;
  logic        stable;
  logic [7:0]  rx;
  logic [8:0]  exp_b;
  always begin
    @(negedge clk);
    if (in_reset) begin
      dec_pos = 0;
      dec_ck  = 8'h00;
    end else if (tx_a === 1'b0) begin
      smp[0]  = tx_a;
      aborted = 1'b0;
      for (int i = 1; i < 40; i++) begin
        @(negedge clk);
        smp[i] = tx_a;
        if (in_reset) aborted = 1'b1;
      end
      if (aborted) begin
        dec_pos = 0;
        dec_ck  = 8'h00;
      end else begin
        stable = 1'b1;
        for (int k = 0; k < 10; k++)
          for (int c = 1; c < 4; c++)
            if (smp[4*k+c] !== smp[4*k]) stable = 1'b0;
        chk("bit_timing", stable, 1);
        chk("framing", {smp[36], smp[0]}, 2'b10);
        for (int b = 0; b < 8; b++) rx[b] = smp[4*(b+1)];
        if (dec_pos == 0) exp_b = 9'h0A5;
        else if (dec_pos <= 16) begin
          if (exp_q.size() > 0) begin
            exp_b  = {1'b0, exp_q.pop_front()};
            dec_ck = dec_ck ^ exp_b[7:0];
          end else exp_b = 9'h100;
        end else exp_b = {1'b0, dec_ck};
        chk($sformatf("rx_byte%0d", dec_pos), rx, exp_b);
        dec_pos++;
        if (dec_pos == 18) begin
          dec_pos = 0;
          dec_ck  = 8'h00;
          rx_frames++;
        end
      end
    end
  end

  // Read handshake monitor for instance A.
  int   rd_cnt = 0;
  logic prev_en = 1'b0;
  logic prev_busy = 1'b0;
  always begin
    @(negedge clk);
    if (in_reset) begin
      rd_cnt    = 0;
      prev_en   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (dbg_a.dbg_rd_en === 1'b1) begin
        chk("rd_pulse_width", prev_en, 0);
        chk("rd_addr", dbg_a.dbg_addr, rd_cnt);
        rd_cnt++;
      end else if (busy_a && rd_cnt > 0) begin
        chk("addr_hold", dbg_a.dbg_addr, rd_cnt - 1);
      end
      if (prev_busy && !busy_a) begin
        chk("rd_count", rd_cnt, 8);
        rd_cnt = 0;
      end
      prev_en   = dbg_a.dbg_rd_en;
      prev_busy = busy_a;
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return ovr_b;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic lvl, input int max,
                          output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig(sel) !== lvl && n < max);
    chk(tag, sig(sel), lvl);
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (dec_pos != p && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_byte", dec_pos, p);
  endtask

  initial begin
    int n;
    int rises;
    rst_a = 1'b1;
    rst_b = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_rd_en", dbg_a.dbg_rd_en, 0);
    chk("rst_addr", dbg_a.dbg_addr, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_overrun", ovr_a, 0);
    rst_a    = 1'b0;
    rst_b    = 1'b0;
    in_reset = 1'b0;

    // Basic frame: reg0=1234, rest zero
    en_a = 1'b1;
    wait_for("a_start", 0, 1'b1, 1100, n);
    chk("first_trigger", n, 1000);
    chk("start_bit", tx_a, 0);
    wait_for("a_end", 0, 1'b0, 900, n);
    chk("frame_len", n, 754);
    chk("count1", cnt_a, 1);
    chk("overrun_a", ovr_a, 0);
    chk("rx_frames1", rx_frames, 1);

    // Checksum sweep
    mode = 1;
    wait_for("a_start2", 0, 1'b1, 400, n);
    chk("period", n, 246);
    wait_for("a_end2", 0, 1'b0, 900, n);
    chk("count2", cnt_a, 2);
    chk("rx_frames2", rx_frames, 2);

    // Enable dropped mid-frame
    wait_for("a_start3", 0, 1'b1, 400, n);
    wait_pos(5);
    en_a = 1'b0;
    wait_for("a_end3", 0, 1'b0, 900, n);
    chk("count3", cnt_a, 3);
    chk("rx_frames3", rx_frames, 3);
    rises = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (busy_a) rises++;
    end
    chk("idle_no_trigger", rises, 0);
    en_a = 1'b1;
    wait_for("a_start4", 0, 1'b1, 1100, n);
    chk("reenable_trigger", n, 1000);
    wait_for("a_end4", 0, 1'b0, 900, n);
    chk("count4", cnt_a, 4);
    chk("rx_frames4", rx_frames, 4);

    // Reset during the reg3 hi byte
    wait_for("a_start5", 0, 1'b1, 400, n);
    wait_pos(7);
    repeat (20) @(negedge clk);
    in_reset = 1'b1;
    rst_a    = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", tx_a, 1);
    chk("mid_rst_rd_en", dbg_a.dbg_rd_en, 0);
    chk("mid_rst_addr", dbg_a.dbg_addr, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_count", cnt_a, 0);
    chk("mid_rst_overrun", ovr_a, 0);
    rst_a = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    in_reset = 1'b0;
    wait_for("a_start6", 0, 1'b1, 1100, n);
    wait_for("a_end6", 0, 1'b0, 900, n);
    chk("frame_len_after_rst", n, 754);
    chk("count_after_rst", cnt_a, 1);
    chk("rx_frames5", rx_frames, 5);
    en_a = 1'b0;

    // Overrun on the 500-cycle instance
    en_b = 1'b1;
    wait_for("b_start", 1, 1'b1, 600, n);
    chk("b_first_trigger", n, 500);
    wait_for("b_overrun", 2, 1'b1, 600, n);
    chk("overrun_delay", n, 500);
    chk("overrun_in_frame", busy_b, 1);
    wait_for("b_end", 1, 1'b0, 400, n);
    chk("b_count1", cnt_b, 1);
    wait_for("b_start2", 1, 1'b1, 400, n);
    chk("b_skip_period", n, 246);
    wait_for("b_end2", 1, 1'b0, 900, n);
    chk("b_count2", cnt_b, 2);
    chk("overrun_sticky", ovr_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
